// File: rtl/fp_normalize_seq.sv
// Sequential post-add normaliser for the floating-point adder datapath.
// Accepts a raw sum (carry, hidden bit, fraction) plus exponent, fixes a
// carry-out with a single right shift or left-normalises one bit per clock,
// and flags zero, overflow (saturate to Inf) and underflow (flush to zero).
// Handshake is valid/ready on both sides; one transaction in flight at a time.
module fp_normalize_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sign,
  input  logic [EXP_W-1:0]   in_exp,
  input  logic [MAN_W+1:0]   in_frac,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic [EXP_W-1:0]   out_exp,
  output logic [MAN_W-1:0]   out_man,
  output logic               out_zero,
  output logic               out_ovf,
  output logic               out_unf,
  output logic               busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NORM = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [EXP_W-1:0] EXP_MAX  = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
  localparam logic [MAN_W-1:0] MAN_ZERO = {MAN_W{1'b0}};
  localparam logic [MAN_W+1:0] FRAC_ZERO = {(MAN_W+2){1'b0}};

  // FSM and working registers
  logic [1:0]       state_q, state_d;
  logic             sign_q,  sign_d;
  logic [EXP_W-1:0] exp_q,   exp_d;
  logic [MAN_W+1:0] frac_q,  frac_d;

  // Result registers driving the outputs directly
  logic             out_valid_q, out_valid_d;
  logic             out_sign_q,  out_sign_d;
  logic [EXP_W-1:0] out_exp_q,   out_exp_d;
  logic [MAN_W-1:0] out_man_q,   out_man_d;
  logic             out_zero_q,  out_zero_d;
  logic             out_ovf_q,   out_ovf_d;
  logic             out_unf_q,   out_unf_d;
  logic             busy_q,      busy_d;

  // Result of the current NORM decision, applied only when finish_s is set
  logic             finish_s;
  logic [EXP_W-1:0] res_exp_s;
  logic [MAN_W-1:0] res_man_s;
  logic             res_zero_s;
  logic             res_ovf_s;
  logic             res_unf_s;
  logic [EXP_W-1:0] exp_inc_s;

  assign exp_inc_s = exp_q + EXP_ONE;

  // Prioritised normalisation decision for the current working value
  always_comb begin
    finish_s   = 1'b0;
    res_exp_s  = exp_q;
    res_man_s  = frac_q[MAN_W-1:0];
    res_zero_s = 1'b0;
    res_ovf_s  = 1'b0;
    res_unf_s  = 1'b0;
    if (exp_q == EXP_MAX) begin
      // Inf/NaN on input: pass through untouched
      finish_s = 1'b1;
    end else if (frac_q[MAN_W+1]) begin
      // Carry-out: one right shift, LSB dropped
      finish_s = 1'b1;
      if (exp_inc_s == EXP_MAX) begin
        res_exp_s = EXP_MAX;
        res_man_s = MAN_ZERO;
        res_ovf_s = 1'b1;
      end else begin
        res_exp_s = exp_inc_s;
        res_man_s = frac_q[MAN_W:1];
      end
    end else if (frac_q == FRAC_ZERO) begin
      finish_s   = 1'b1;
      res_exp_s  = EXP_ZERO;
      res_man_s  = MAN_ZERO;
      res_zero_s = 1'b1;
    end else if (frac_q[MAN_W]) begin
      finish_s = 1'b1;
    end else if (exp_q <= EXP_ONE) begin
      // No denormals: flush to zero rather than shift below exponent 1
      finish_s  = 1'b1;
      res_exp_s = EXP_ZERO;
      res_man_s = MAN_ZERO;
      res_unf_s = 1'b1;
    end else begin
      finish_s = 1'b0;
    end
  end

  // Next-state logic for the FSM, working registers and result registers
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    frac_d      = frac_q;
    out_valid_d = out_valid_q;
    out_sign_d  = out_sign_q;
    out_exp_d   = out_exp_q;
    out_man_d   = out_man_q;
    out_zero_d  = out_zero_q;
    out_ovf_d   = out_ovf_q;
    out_unf_d   = out_unf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d     = in_sign;
          exp_d      = in_exp;
          frac_d     = in_frac;
          out_zero_d = 1'b0;
          out_ovf_d  = 1'b0;
          out_unf_d  = 1'b0;
          state_d    = S_NORM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_NORM: begin
        if (finish_s) begin
          out_valid_d = 1'b1;
          out_sign_d  = sign_q;
          out_exp_d   = res_exp_s;
          out_man_d   = res_man_s;
          out_zero_d  = res_zero_s;
          out_ovf_d   = res_ovf_s;
          out_unf_d   = res_unf_s;
          state_d     = S_DONE;
        end else begin
          frac_d  = {frac_q[MAN_W:0], 1'b0};
          exp_d   = exp_q - EXP_ONE;
          state_d = S_NORM;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sign_q      <= 1'b0;
      exp_q       <= EXP_ZERO;
      frac_q      <= FRAC_ZERO;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= EXP_ZERO;
      out_man_q   <= MAN_ZERO;
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      frac_q      <= frac_d;
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      out_exp_q   <= out_exp_d;
      out_man_q   <= out_man_d;
      out_zero_q  <= out_zero_d;
      out_ovf_q   <= out_ovf_d;
      out_unf_q   <= out_unf_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) & ~rst;
  assign out_valid = out_valid_q;
  assign out_sign  = out_sign_q;
  assign out_exp   = out_exp_q;
  assign out_man   = out_man_q;
  assign out_zero  = out_zero_q;
  assign out_ovf   = out_ovf_q;
  assign out_unf   = out_unf_q;
  assign busy      = busy_q;

endmodule
